// File: rtl/hash_enc_pkg.sv
// Shared definitions for the hash level scheduler: FSM state encoding,
// default sizes and the level index width helper.
package hash_enc_pkg;

  localparam int unsigned DATA_SIZE_DEF  = 32;
  localparam int unsigned NUM_LEVELS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  // Width of a level index; never below one bit so a single-level build still has a port
  function automatic int unsigned lvl_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hash_level_cfg.sv
// Per-level resolution table: one write port, one combinational read port,
// cleared by synchronous reset.
module hash_level_cfg
  import hash_enc_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
  parameter int unsigned NUM_LEVELS = NUM_LEVELS_DEF,
  localparam int unsigned LW        = lvl_width(NUM_LEVELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [LW-1:0]        wr_level,
  input  logic [DATA_SIZE-1:0] wr_res,
  input  logic [LW-1:0]        rd_level,
  output logic [DATA_SIZE-1:0] rd_res
);

  logic [DATA_SIZE-1:0] res_tbl [NUM_LEVELS];

  // Table storage; writes to levels beyond the table are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LEVELS; i++) res_tbl[i] <= '0;
    end else if (we && (32'(wr_level) < NUM_LEVELS)) begin
      res_tbl[wr_level] <= wr_res;
    end
  end

  // Combinational read of the current level's resolution
  always_comb begin
    rd_res = '0;
    if (32'(rd_level) < NUM_LEVELS) rd_res = res_tbl[rd_level];
  end

endmodule

// File: rtl/hash_level_sched.sv
// Multiresolution hash level scheduler: accepts a point, issues one
// index calculation per level, waits the fixed unit latency, captures the
// eight corner indices and hands them out with a valid/ready handshake.
// Optional performance counters are enabled with HASH_SCHED_PERF_EN.
module hash_level_sched
  import hash_enc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = DATA_SIZE_DEF,
  parameter int unsigned NUM_LEVELS   = NUM_LEVELS_DEF,
  parameter int unsigned CALC_LATENCY = 6,
  localparam int unsigned LW          = lvl_width(NUM_LEVELS),
  localparam int unsigned CW          = $clog2(CALC_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [DATA_SIZE-1:0] pt_x,
  input  logic [DATA_SIZE-1:0] pt_y,
  input  logic [DATA_SIZE-1:0] pt_z,
  input  logic                 cfg_we,
  input  logic [LW-1:0]        cfg_level,
  input  logic [DATA_SIZE-1:0] cfg_res,
  output logic                 cfg_err,
  output logic                 calc_en,
  output logic [DATA_SIZE-1:0] calc_x,
  output logic [DATA_SIZE-1:0] calc_y,
  output logic [DATA_SIZE-1:0] calc_z,
  output logic [DATA_SIZE-1:0] calc_res [0:2],
  input  logic [DATA_SIZE-1:0] calc_hash_idx [0:7],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        out_level,
  output logic                 out_last,
  output logic [DATA_SIZE-1:0] out_hash_idx [0:7],
  output logic                 busy
`ifdef HASH_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_points,
  output logic [31:0]          perf_stalls
`endif
);

  localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
  localparam logic [CW-1:0] LAST_WAIT  = CW'(CALC_LATENCY - 1);

  state_t               state;
  logic [LW-1:0]        level;
  logic [CW-1:0]        wait_cnt;
  logic [DATA_SIZE-1:0] rd_res;

  // Table writes are only honoured while idle
  hash_level_cfg #(
    .DATA_SIZE  (DATA_SIZE),
    .NUM_LEVELS (NUM_LEVELS)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we && (state == IDLE)),
    .wr_level (cfg_level),
    .wr_res   (cfg_res),
    .rd_level (level),
    .rd_res   (rd_res)
  );

  // Same resolution on all three axes
  always_comb begin
    for (int unsigned a = 0; a < 3; a++) calc_res[a] = rd_res;
  end

  assign out_level = level;
  // Gated by busy so the idle/reset value is 0 even for a single-level build
  assign out_last  = busy && (level == LAST_LEVEL);

  // Scheduler FSM with registered handshake and strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      level     <= '0;
      wait_cnt  <= '0;
      pt_ready  <= 1'b1;
      busy      <= 1'b0;
      calc_en   <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      calc_x    <= '0;
      calc_y    <= '0;
      calc_z    <= '0;
      for (int unsigned k = 0; k < 8; k++) out_hash_idx[k] <= '0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (pt_valid) begin
            calc_x   <= pt_x;
            calc_y   <= pt_y;
            calc_z   <= pt_z;
            level    <= '0;
            pt_ready <= 1'b0;
            busy     <= 1'b1;
            calc_en  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          calc_en  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            for (int unsigned k = 0; k < 8; k++) out_hash_idx[k] <= calc_hash_idx[k];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (level == LAST_LEVEL) begin
              pt_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              level   <= level + 1'b1;
              calc_en <= 1'b1;
              state   <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_SCHED_PERF_EN
  // Completed-point and output-stall counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_points <= '0;
      perf_stalls <= '0;
    end else begin
      if (out_valid && out_ready && out_last) perf_points <= perf_points + 32'd1;
      if (out_valid && !out_ready)            perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hash_level_sched.md
HASH_LEVEL_SCHED -- requirements
Module: hash_level_sched

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, width of coordinates, resolutions and hash indices.
REQ-002 SHALL have parameter NUM_LEVELS, default 16, number of multiresolution levels per point.
REQ-003 SHALL have parameter CALC_LATENCY, default 6, cycles from calc_en to valid calc_hash_idx.
REQ-004 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous and active-high.
- pt_valid  in  1  point offered.
- pt_ready  out  1  point accepted when high with pt_valid.
- pt_x, pt_y, pt_z  in  DATA_SIZE each  point coordinates.
- cfg_we  in  1  level resolution write strobe.
- cfg_level  in  $clog2(NUM_LEVELS)  level written.
- cfg_res  in  DATA_SIZE  resolution for that level, applied to all 3 axes.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- calc_en  out  1  start pulse to the index-calculation unit.
- calc_x, calc_y, calc_z  out  DATA_SIZE each  coordinates to the unit.
- calc_res[0:2]  out  DATA_SIZE  per-axis resolution to the unit.
- calc_hash_idx[0:7]  in  DATA_SIZE  8 corner indices from the unit.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_level  out  $clog2(NUM_LEVELS)  level of the result.
- out_last  out  1  result belongs to the final level.
- out_hash_idx[0:7]  out  DATA_SIZE  captured corner indices.
- busy  out  1  high in every state other than IDLE.

Function
REQ-005 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> OUT. OUT SHALL go to ISSUE while levels remain, else to IDLE.
REQ-006 In IDLE, pt_ready SHALL be 1. On pt_valid&pt_ready the block SHALL latch pt_x/y/z, clear the level counter and enter ISSUE. In all other states pt_ready SHALL be 0.
REQ-007 ISSUE SHALL last exactly one cycle with calc_en=1 and calc_res[0..2]=cfg table[level]. calc_x/y/z SHALL hold the latched point in every state.
REQ-008 WAIT SHALL count exactly CALC_LATENCY cycles. In the last WAIT cycle the block SHALL capture calc_hash_idx[0:7] into out_hash_idx.
REQ-009 In OUT, out_valid SHALL be 1 and out_level, out_hash_idx and out_last SHALL stay stable until out_ready. out_ready asserted on the first OUT cycle SHALL complete the transfer in that cycle.
REQ-010 out_last SHALL be 1 iff level == NUM_LEVELS-1.
REQ-011 Minimum cost per level SHALL be CALC_LATENCY+2 cycles. Each OUT stall cycle SHALL add exactly one cycle.
REQ-012 Level counter and WAIT counter SHALL be unsigned; the level counter SHALL never exceed NUM_LEVELS-1.
REQ-013 cfg_we in IDLE SHALL write the table at the next edge. If cfg_we and pt_valid occur in the same IDLE cycle, the write SHALL apply before the first ISSUE.
REQ-014 cfg_we while busy=1 SHALL NOT change the table and SHALL pulse cfg_err for exactly one cycle.
REQ-015 calc_en SHALL never be asserted outside ISSUE. No second calc_en SHALL occur before the previous capture.

Reset
REQ-016 rst SHALL put the FSM in IDLE and clear both counters, including mid-operation. Any in-flight level SHALL be abandoned with no output.
REQ-017 Under rst every output SHALL be 0 except pt_ready=1. All table entries SHALL be 0 and out_hash_idx SHALL be 0.

Configuration
REQ-018 With HASH_SCHED_PERF_EN defined, the block SHALL add:
- out port perf_points [31:0], counting completed points (OUT transfer with out_last).
- out port perf_stalls [31:0], counting cycles with out_valid&!out_ready.
- Both counters SHALL wrap at 2^32 and be cleared by rst.
REQ-019 Without HASH_SCHED_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-020 Package hash_enc_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT, OUT), DATA_SIZE and NUM_LEVELS defaults, and the level index width function.
REQ-021 The resolution table SHALL be sub-module hash_level_cfg: write port, one combinational read port, synchronous reset clear.

Verification (NUM_LEVELS=4, CALC_LATENCY=6)
REQ-022 Table res={16,32,64,128}, one point, out_ready=1 -> four results with levels 0..3 and out_last only on level 3. calc_en is seen 8 cycles apart with calc_res 16,32,64,128. pt_ready returns 1 after 32 cycles.
REQ-023 Stub unit returns 0x1000+k on corner k, 6 cycles after calc_en -> out_hash_idx[k]=0x1000+k. Changing the stub value on any other cycle does not change the output.
REQ-024 out_ready held 0 for 5 cycles on level 1 -> out_valid and data stay stable, the next calc_en is delayed exactly 5 cycles, and perf_stalls=5.
REQ-025 cfg_we while busy, level 2, res 99 -> cfg_err pulse of 1 cycle and level 2 still uses 64. The same write in IDLE -> the next point uses 99.
REQ-026 rst asserted in WAIT of level 2 -> next cycle: IDLE, pt_ready=1, out_valid=0. A new point then starts again at level 0.
REQ-027 Back-to-back points with pt_valid held high -> the second point is accepted exactly one cycle after the first point's level-3 transfer, and perf_points=2.
